// File: rtl/acc_mem_arbiter_pkg.sv
// Shared types for the accelerator memory arbiter: FSM state, operation kind,
// and the index-width helper used for port numbers.
package acc_mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} arb_state_t;
  typedef enum logic {OP_RD, OP_WR} arb_op_t;

  // A single-port build still needs a 1-bit index rather than a zero-width one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first set request bit at or
// after ptr, wrapping around to bit 0.
module rr_picker
  import acc_mem_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  int idx;

  // Scan from the farthest offset down so the closest requester overwrites last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/acc_mem_arbiter.sv
// Responder side of the accelerator memory protocol: round-robin arbitration of
// level-held read/write requests onto one Data Memory port, one access at a time.
module acc_mem_arbiter
  import acc_mem_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int ADDR_SIZE      = 16,
  parameter int RD_DATA_SIZE   = 512,
  parameter int WR_DATA_SIZE   = 32,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_REQ-1:0]                req_rd_en,
  input  logic [N_REQ*ADDR_SIZE-1:0]      req_rd_addr,
  input  logic [N_REQ-1:0]                req_wr_en,
  input  logic [N_REQ*ADDR_SIZE-1:0]      req_wr_addr,
  input  logic [N_REQ*WR_DATA_SIZE-1:0]   req_wr_data,
  output logic [N_REQ-1:0]                rsp_rd_valid,
  output logic [RD_DATA_SIZE-1:0]         rsp_rd_data,
  output logic [N_REQ-1:0]                rsp_wr_done,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_SIZE-1:0]            mem_addr,
  output logic [WR_DATA_SIZE-1:0]         mem_wdata,
  input  logic [RD_DATA_SIZE-1:0]         mem_rdata
);

  localparam int IW = idx_width(N_REQ);
  localparam int CW = $clog2(MEM_RD_LATENCY + 1);

  // Handshake: a port raises rd_en or wr_en and holds it, with stable address
  // and data, until its one-cycle rsp_rd_valid / rsp_wr_done bit fires.

  arb_state_t              state_q, state_d;
  arb_op_t                 op_q, op_d;
  logic [IW-1:0]           gnt_q, gnt_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [ADDR_SIZE-1:0]    addr_q, addr_d;
  logic [WR_DATA_SIZE-1:0] wdata_q, wdata_d;
  logic [RD_DATA_SIZE-1:0] rd_data_q, rd_data_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic [N_REQ-1:0]        req_any;
  logic                    pick_valid;
  logic [IW-1:0]           pick_idx;
  logic [N_REQ-1:0]        gnt_oh;

  assign req_any = req_rd_en | req_wr_en;

  rr_picker #(.N(N_REQ)) u_picker (
    .req         (req_any),
    .ptr         (ptr_q),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          // A port asserting both enables gets its write first; the read waits.
          gnt_d   = pick_idx;
          op_d    = req_wr_en[pick_idx] ? OP_WR : OP_RD;
          addr_d  = req_wr_en[pick_idx]
                    ? req_wr_addr[int'(pick_idx)*ADDR_SIZE +: ADDR_SIZE]
                    : req_rd_addr[int'(pick_idx)*ADDR_SIZE +: ADDR_SIZE];
          wdata_d = req_wr_data[int'(pick_idx)*WR_DATA_SIZE +: WR_DATA_SIZE];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (op_q == OP_WR) begin
          state_d = RESP;
        end else begin
          cnt_d   = CW'(1);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == CW'(MEM_RD_LATENCY)) begin
          rd_data_d = mem_rdata;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        ptr_d   = (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_RD;
      gnt_q     <= '0;
      ptr_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      cnt_q     <= cnt_d;
    end
  end

  // Outputs come from state and registers only, never straight from req_*.
  always_comb begin
    gnt_oh        = '0;
    gnt_oh[gnt_q] = 1'b1;
  end

  assign mem_en       = (state_q == ISSUE);
  assign mem_we       = mem_en && (op_q == OP_WR);
  assign mem_addr     = mem_en ? addr_q : '0;
  assign mem_wdata    = mem_we ? wdata_q : '0;
  assign rsp_rd_valid = (state_q == RESP && op_q == OP_RD) ? gnt_oh : '0;
  assign rsp_wr_done  = (state_q == RESP && op_q == OP_WR) ? gnt_oh : '0;
  assign rsp_rd_data  = rd_data_q;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Bench for acc_mem_arbiter: a latency-1 instance driven by table vectors, hand
// sequences and random traffic, plus a latency-3 instance for timing and reset.
module tb_acc_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int RW = 512;
  localparam int WW = 32;
  localparam int L1 = 1;
  localparam int L3 = 3;
  localparam logic [RW-1:0] GARB = {16{32'hBAD0_BAD0}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A (latency 1) ----------------
  logic [N-1:0]    a_rd_en, a_wr_en;
  logic [N*AW-1:0] a_rd_addr, a_wr_addr;
  logic [N*WW-1:0] a_wr_data;
  logic [N-1:0]    a_rsp_rd_valid, a_rsp_wr_done;
  logic [RW-1:0]   a_rsp_rd_data, a_mem_rdata;
  logic            a_mem_en, a_mem_we;
  logic [AW-1:0]   a_mem_addr;
  logic [WW-1:0]   a_mem_wdata;

  acc_mem_arbiter #(.N_REQ(N), .ADDR_SIZE(AW), .RD_DATA_SIZE(RW),
                    .WR_DATA_SIZE(WW), .MEM_RD_LATENCY(L1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_rd_en(a_rd_en), .req_rd_addr(a_rd_addr),
    .req_wr_en(a_wr_en), .req_wr_addr(a_wr_addr), .req_wr_data(a_wr_data),
    .rsp_rd_valid(a_rsp_rd_valid), .rsp_rd_data(a_rsp_rd_data),
    .rsp_wr_done(a_rsp_wr_done),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  // ---------------- DUT B (latency 3) ----------------
  logic [N-1:0]    b_rd_en, b_wr_en;
  logic [N*AW-1:0] b_rd_addr, b_wr_addr;
  logic [N*WW-1:0] b_wr_data;
  logic [N-1:0]    b_rsp_rd_valid, b_rsp_wr_done;
  logic [RW-1:0]   b_rsp_rd_data, b_mem_rdata;
  logic            b_mem_en, b_mem_we;
  logic [AW-1:0]   b_mem_addr;
  logic [WW-1:0]   b_mem_wdata;

  acc_mem_arbiter #(.N_REQ(N), .ADDR_SIZE(AW), .RD_DATA_SIZE(RW),
                    .WR_DATA_SIZE(WW), .MEM_RD_LATENCY(L3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_rd_en(b_rd_en), .req_rd_addr(b_rd_addr),
    .req_wr_en(b_wr_en), .req_wr_addr(b_wr_addr), .req_wr_data(b_wr_data),
    .rsp_rd_valid(b_rsp_rd_valid), .rsp_rd_data(b_rsp_rd_data),
    .rsp_wr_done(b_rsp_wr_done),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // ---------------- memory models: line valid exactly L cycles after issue ----------------
  function automatic logic [RW-1:0] line_of(input logic [AW-1:0] a);
    return {16{a, a ^ 16'hA5A5}};
  endfunction

  logic [RW-1:0] a_pipe [L1];
  logic          a_pv   [L1];
  logic [RW-1:0] b_pipe [L3];
  logic          b_pv   [L3];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < L1; i++) a_pv[i] <= 1'b0;
    end else begin
      a_pv[0] <= a_mem_en & ~a_mem_we;
      for (int i = L1 - 1; i > 0; i--) a_pv[i] <= a_pv[i-1];
    end
    a_pipe[0] <= line_of(a_mem_addr);
    for (int i = L1 - 1; i > 0; i--) a_pipe[i] <= a_pipe[i-1];
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < L3; i++) b_pv[i] <= 1'b0;
    end else begin
      b_pv[0] <= b_mem_en & ~b_mem_we;
      for (int i = L3 - 1; i > 0; i--) b_pv[i] <= b_pv[i-1];
    end
    b_pipe[0] <= line_of(b_mem_addr);
    for (int i = L3 - 1; i > 0; i--) b_pipe[i] <= b_pipe[i-1];
  end

  assign a_mem_rdata = (a_pv[L1-1] === 1'b1) ? a_pipe[L1-1] : GARB;
  assign b_mem_rdata = (b_pv[L3-1] === 1'b1) ? b_pipe[L3-1] : GARB;

  // ---------------- scoreboard counters / check ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_rd_en = '0; a_wr_en = '0; a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0;
    b_rd_en = '0; b_wr_en = '0; b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic a_set(input int p, input bit rd, input bit wr,
                       input logic [AW-1:0] addr, input logic [WW-1:0] data);
    a_rd_en[p] = rd;
    a_wr_en[p] = wr;
    a_rd_addr[p*AW +: AW] = addr;
    a_wr_addr[p*AW +: AW] = addr;
    a_wr_data[p*WW +: WW] = data;
  endtask

  task automatic b_set_rd(input int p, input bit rd, input logic [AW-1:0] addr);
    b_rd_en[p] = rd;
    b_rd_addr[p*AW +: AW] = addr;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_outs"}, RW'({a_rsp_rd_valid, a_rsp_wr_done, a_mem_en, a_mem_we,
                              a_mem_addr, a_mem_wdata}), '0);
    chk({tag, "_a_rdata"}, a_rsp_rd_data, '0);
    chk({tag, "_b_outs"}, RW'({b_rsp_rd_valid, b_rsp_wr_done, b_mem_en, b_mem_we,
                              b_mem_addr, b_mem_wdata}), '0);
    chk({tag, "_b_rdata"}, b_rsp_rd_data, '0);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    int            port;
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [WW-1:0] wdata;
    int            exp_cyc;   // cycle of the response pulse, request = cycle 0
    logic [N-1:0]  exp_oh;
  } vec_t;

  vec_t vt [6];

  // ---------------- random-test model state ----------------
  bit            pend [N];
  bit            m_busy;
  int            m_port, m_issue, m_resp, m_ptr, cyc;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [WW-1:0] m_wdata;
  logic [RW-1:0] m_rd_data;

  initial begin
    int            p, nr, nv, hit;
    logic [1:0]    exp_q [$];
    bit            seen0, seen3;
    logic [N-1:0]  e_rdv, e_wrd;
    logic [AW-1:0] ra;
    logic [WW-1:0] rd_word;

    clear_inputs();
    do_reset();
    chk_all_zero("reset");

    // ---- table-driven single transactions on the latency-1 instance ----
    vt[0] = '{0, 1'b1, 16'h5000, 32'h0000_0005, 2, 4'b0001};
    vt[1] = '{2, 1'b0, 16'h1000, 32'h0,         3, 4'b0100};
    vt[2] = '{3, 1'b1, 16'hFFFF, 32'hDEAD_BEEF, 2, 4'b1000};
    vt[3] = '{1, 1'b0, 16'h0000, 32'h0,         3, 4'b0010};
    vt[4] = '{3, 1'b0, 16'hABCD, 32'h0,         3, 4'b1000};
    vt[5] = '{0, 1'b1, 16'h0001, 32'hFFFF_FFFF, 2, 4'b0001};

    for (int v = 0; v < 6; v++) begin
      a_set(vt[v].port, !vt[v].is_wr, vt[v].is_wr, vt[v].addr, vt[v].wdata);
      for (int c = 1; c <= vt[v].exp_cyc; c++) begin
        step();
        if (c == 1) begin
          chk("vec_mem_en", RW'(a_mem_en), RW'(1'b1));
          chk("vec_mem_we", RW'(a_mem_we), RW'(vt[v].is_wr));
          chk("vec_mem_addr", RW'(a_mem_addr), RW'(vt[v].addr));
          chk("vec_mem_wdata", RW'(a_mem_wdata), vt[v].is_wr ? RW'(vt[v].wdata) : '0);
        end else begin
          chk("vec_no_mem_en", RW'(a_mem_en), '0);
        end
        if (c < vt[v].exp_cyc) begin
          chk("vec_early_rsp", RW'({a_rsp_rd_valid, a_rsp_wr_done}), '0);
        end
      end
      chk("vec_wr_done", RW'(a_rsp_wr_done), vt[v].is_wr ? RW'(vt[v].exp_oh) : '0);
      chk("vec_rd_valid", RW'(a_rsp_rd_valid), vt[v].is_wr ? '0 : RW'(vt[v].exp_oh));
      if (!vt[v].is_wr) chk("vec_rd_data", a_rsp_rd_data, line_of(vt[v].addr));
      a_set(vt[v].port, 1'b0, 1'b0, '0, '0);
      step();
      chk("vec_pulse_once", RW'({a_rsp_rd_valid, a_rsp_wr_done}), '0);
      if (!vt[v].is_wr) chk("vec_rd_hold", a_rsp_rd_data, line_of(vt[v].addr));
    end

    // ---- held read: port0 keeps rd_en high through its response cycle ----
    nr = 0; nv = 0;
    a_set(0, 1'b1, 1'b0, 16'h2222, '0);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (a_mem_en && !a_mem_we) nr++;
      if (a_rsp_rd_valid[0]) nv++;
      if (c == 4) a_set(0, 1'b0, 1'b0, '0, '0);
    end
    chk("held_mem_reads", RW'(nr), RW'(1));
    chk("held_valid_pulses", RW'(nv), RW'(1));

    // ---- rd_en and wr_en together on port1: write first, then the read ----
    a_rd_en[1] = 1'b1; a_rd_addr[1*AW +: AW] = 16'h3333;
    a_wr_en[1] = 1'b1; a_wr_addr[1*AW +: AW] = 16'h4444; a_wr_data[1*WW +: WW] = 32'h77;
    step();
    chk("both_first_we", RW'(a_mem_we), RW'(1'b1));
    chk("both_first_addr", RW'(a_mem_addr), RW'(16'h4444));
    step();
    chk("both_wr_done", RW'(a_rsp_wr_done), RW'(4'b0010));
    chk("both_no_rd_yet", RW'(a_rsp_rd_valid), '0);
    step();
    a_wr_en[1] = 1'b0;
    step();
    chk("both_rd_issue", RW'({a_mem_en, a_mem_we}), RW'(2'b10));
    chk("both_rd_addr", RW'(a_mem_addr), RW'(16'h3333));
    step();
    step();
    chk("both_rd_valid", RW'(a_rsp_rd_valid), RW'(4'b0010));
    chk("both_rd_data", a_rsp_rd_data, line_of(16'h3333));
    step();
    a_rd_en[1] = 1'b0;

    // ---- contention from reset: all four ports hold writes ----
    do_reset();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
    seen0 = 1'b0; seen3 = 1'b0;
    for (int q = 0; q < N; q++) a_set(q, 1'b0, 1'b1, AW'(16'h0100 + q), WW'(q));
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      step();
      if (a_rsp_wr_done != '0) begin
        chk("cont_onehot", RW'($onehot(a_rsp_wr_done)), RW'(1'b1));
        p = 0;
        for (int q = 0; q < N; q++) if (a_rsp_wr_done[q]) p = q;
        chk("cont_order", RW'(p), RW'(exp_q.pop_front()));
        if (p == 0 && !seen0) begin
          seen0 = 1'b1;
          a_set(0, 1'b0, 1'b1, 16'h0200, 32'h20);
        end else if (p == 3 && !seen3) begin
          seen3 = 1'b1;
          a_set(3, 1'b0, 1'b1, 16'h0203, 32'h23);
        end else begin
          a_set(p, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    chk("cont_all_served", RW'(exp_q.size()), '0);
    clear_inputs();
    step();

    // ---- latency-3 read on port1: valid at cycle 5, memory quiet while waiting ----
    b_set_rd(1, 1'b1, 16'h1234);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) chk("l3_issue", RW'({b_mem_en, b_mem_we}), RW'(2'b10));
      if (c >= 2 && c <= 4) chk("l3_quiet", RW'({b_mem_en, b_rsp_rd_valid}), '0);
      if (c == 5) begin
        chk("l3_valid", RW'(b_rsp_rd_valid), RW'(4'b0010));
        chk("l3_data", b_rsp_rd_data, line_of(16'h1234));
        b_set_rd(1, 1'b0, '0);
      end
      if (c == 6) chk("l3_once", RW'(b_rsp_rd_valid), '0);
    end

    // ---- reset in RD_WAIT discards the read; pointer restarts at 0 ----
    b_set_rd(3, 1'b1, 16'h5678);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    clear_inputs();
    chk_all_zero("midrd_reset");
    hit = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (b_rsp_rd_valid != '0 || b_mem_en) hit++;
    end
    chk("midrd_no_stale", RW'(hit), '0);
    b_set_rd(1, 1'b1, 16'h0C01);
    b_set_rd(3, 1'b1, 16'h0C03);
    step();
    chk("post_rst_grant_addr", RW'(b_mem_addr), RW'(16'h0C01));
    for (int c = 2; c <= 5; c++) step();
    chk("post_rst_valid", RW'(b_rsp_rd_valid), RW'(4'b0010));
    clear_inputs();
    step();

    // ---- randomized traffic on the latency-1 instance against the model ----
    do_reset();
    for (int q = 0; q < N; q++) pend[q] = 1'b0;
    m_busy = 1'b0; m_ptr = 0; cyc = 0; m_rd_data = '0;
    m_port = 0; m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_issue = 0; m_resp = 0;
    for (int it = 0; it < 1500; it++) begin
      step();
      cyc++;
      if (m_busy && cyc == m_resp + 1) m_busy = 1'b0;
      e_rdv = '0; e_wrd = '0;
      if (m_busy && cyc == m_resp) begin
        if (m_wr) e_wrd[m_port] = 1'b1;
        else begin
          e_rdv[m_port] = 1'b1;
          m_rd_data = line_of(m_addr);
        end
      end
      chk("rnd_mem_en", RW'(a_mem_en), RW'(m_busy && cyc == m_issue));
      chk("rnd_mem_we", RW'(a_mem_we), RW'(m_busy && cyc == m_issue && m_wr));
      chk("rnd_mem_addr", RW'(a_mem_addr), (m_busy && cyc == m_issue) ? RW'(m_addr) : '0);
      chk("rnd_mem_wdata", RW'(a_mem_wdata),
          (m_busy && cyc == m_issue && m_wr) ? RW'(m_wdata) : '0);
      chk("rnd_rd_valid", RW'(a_rsp_rd_valid), RW'(e_rdv));
      chk("rnd_wr_done", RW'(a_rsp_wr_done), RW'(e_wrd));
      chk("rnd_rd_data", a_rsp_rd_data, m_rd_data);

      // requesters: retire on response, otherwise maybe start a new request
      for (int q = 0; q < N; q++) begin
        if (e_rdv[q] || e_wrd[q]) begin
          pend[q] = 1'b0;
          a_set(q, 1'b0, 1'b0, '0, '0);
        end
        if (!pend[q] && $urandom_range(3, 0) == 0) begin
          pend[q] = 1'b1;
          ra = AW'($urandom);
          rd_word = $urandom;
          if ($urandom_range(1, 0) == 1) a_set(q, 1'b0, 1'b1, ra, rd_word);
          else a_set(q, 1'b1, 1'b0, ra, rd_word);
        end
      end
      // the granted port's address/data may wander; the registered copy must win
      if (m_busy && $urandom_range(1, 0) == 1 && pend[m_port]) begin
        a_rd_addr[m_port*AW +: AW] = AW'($urandom);
        a_wr_addr[m_port*AW +: AW] = AW'($urandom);
        a_wr_data[m_port*WW +: WW] = $urandom;
      end
      if (!m_busy) begin
        for (int k = 0; k < N && !m_busy; k++) begin
          p = (m_ptr + k) % N;
          if (pend[p]) begin
            m_busy  = 1'b1;
            m_port  = p;
            m_wr    = a_wr_en[p];
            m_addr  = m_wr ? a_wr_addr[p*AW +: AW] : a_rd_addr[p*AW +: AW];
            m_wdata = a_wr_data[p*WW +: WW];
            m_issue = cyc + 1;
            m_resp  = cyc + 2 + (m_wr ? 0 : L1);
            m_ptr   = (p + 1) % N;
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
